conv_output_writer: RTL
=======================

Name: conv_output_writer

Overview:
- Output stage of the convolution AFU; sits directly downstream of the IFFT array.
- Accepts 512-bit result cachelines from the IFFT stage (output_valid / cacheline_out) and buffers them in a FIFO.
- Issues QPI write requests to consecutive cacheline addresses, honouring wr_req_almostfull backpressure.
- Counts write responses on both response channels and raises done when every requested line is acknowledged.

Parameters:
ADDR_LMT, 58, width of cacheline write address
MDATA, 14, width of request/response metadata tag
CACHE_WIDTH, 512, cacheline width in bits
FIFO_DEPTH_LOG2, 6, log2 of output buffer depth (64 entries)

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; latches job config
base_addr  in  ADDR_LMT  first destination cacheline address (cacheline units)
num_cl  in  32  number of cachelines in this job
in_valid  in  1  IFFT output_valid
in_data  in  CACHE_WIDTH  IFFT cacheline_out
in_almostfull  out  1  backpressure to upstream scheduler
wr_req_addr  out  ADDR_LMT  write request address
wr_req_mdata  out  MDATA  write request tag
wr_req_data  out  CACHE_WIDTH  write request payload
wr_req_en  out  1  write request valid, one cycle per line
wr_req_almostfull  in  1  QPI write queue almost full
wr_rsp0_valid  in  1  write response channel 0
wr_rsp0_mdata  in  MDATA  tag channel 0 (unused except in sim checks)
wr_rsp1_valid  in  1  write response channel 1
wr_rsp1_mdata  in  MDATA  tag channel 1
done  out  1  job complete, held high until next start
overflow_err  out  1  sticky error flag

Behaviour:
- Clock is clk; reset is synchronous, active-low (reset_n = 0 sampled on a clk edge).
- Reset: state = IDLE; FIFO emptied; all counters = 0. Outputs after reset: wr_req_en, wr_req_addr, wr_req_mdata, wr_req_data, done, in_almostfull and overflow_err all 0. Reset mid-job aborts the job, and pending responses are not tracked.
- Counters, all 32-bit: accepted_cnt (lines pushed into the FIFO), issued_cnt (requests sent), resp_cnt (responses received).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch base_addr and num_cl, clear counters, clear done, go to RUN. If num_cl = 0, go straight to DONE instead.
  - RUN: accept and issue. When issued_cnt reaches num_cl, go to DRAIN.
  - DRAIN: no issue activity; wait until resp_cnt = num_cl, then go to DONE.
  - DONE: done = 1. A new start behaves as it does in IDLE: done drops on the edge that samples start.
- start is ignored in RUN and DRAIN.
- Input accept:
  - Condition: in_valid && state == RUN && accepted_cnt < num_cl && FIFO not full → push in_data; accepted_cnt += 1.
  - in_valid in any other state, or when accepted_cnt ≥ num_cl, drops the data and sets overflow_err.
  - in_valid while the FIFO is full drops the data and sets overflow_err.
  - overflow_err is sticky; only reset clears it (start does not).
- in_almostfull = 1 when FIFO count ≥ 2^FIFO_DEPTH_LOG2 − 4. It is registered from the count.
- Issue: on each edge in RUN, if the FIFO is non-empty and wr_req_almostfull = 0, pop the head and register the request outputs:
  - wr_req_en = 1
  - wr_req_data = head
  - wr_req_addr = base + issued_cnt (ADDR_LMT bits, wraps modulo 2^ADDR_LMT)
  - wr_req_mdata = issued_cnt[MDATA-1:0]
  - then issued_cnt += 1
- Otherwise wr_req_en = 0; addr, data and mdata hold their last values.
- Latency: a line sampled via in_valid at edge t is written to the FIFO at edge t; with an empty FIFO and no backpressure it appears on wr_req_en after edge t+1.
- Throughput is one line per cycle.
- Push and pop in the same cycle leave the count unchanged; a full FIFO with a simultaneous pop still rejects the push (full is evaluated pre-pop).
- Responses: resp_cnt += wr_rsp0_valid + wr_rsp1_valid, so both valid in one cycle adds 2. Responses are counted in RUN and DRAIN and ignored in IDLE and DONE.
- done is asserted on the edge after the one where resp_cnt reaches num_cl. For num_cl = 0, done rises on the edge after start.

Test Plan:
- Basic: start with base_addr=0x1000, num_cl=4; 4 back-to-back in_valid; responses one per cycle on rsp0 → wr_req_addr 0x1000..0x1003 on consecutive cycles, mdata 0..3, data matches input order, done=1 one cycle after the 4th response.
- Backpressure: num_cl=8, hold wr_req_almostfull=1 while 8 lines arrive → no wr_req_en, in_almostfull stays 0 (count 8 < 60); on release, 8 consecutive requests with correct data.
- Dual responses: num_cl=6, rsp0 and rsp1 both valid for 3 cycles → resp_cnt=6, done=1; DRAIN is held until the last pair arrives.
- Full FIFO: almostfull held, push 64 lines (num_cl=100) → in_almostfull=1 from count 60; 65th in_valid is dropped and overflow_err=1; after release exactly 64 lines are written.
- Boundaries: num_cl=0 → done after 1 cycle with no wr_req_en. in_valid in IDLE → overflow_err=1. Extra in_valid after num_cl lines → dropped with overflow_err=1.
- Reset mid-job: reset_n=0 for one edge during RUN with 3 lines buffered → all outputs 0, state IDLE; a new start with num_cl=2 completes normally at base_addr.

Source files
------------

// File: rtl/conv_output_writer.sv
// Convolution AFU output stage: buffers IFFT result lines in a FIFO and
// issues QPI cacheline writes, then counts write responses to signal done.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               one-cycle pulse latching base_addr / num_cl
//   base_addr, num_cl   job destination (cacheline units) and length
//   in_valid, in_data   IFFT result stream
//   in_almostfull       backpressure to upstream scheduler
//   wr_req_*            QPI write request channel
//   wr_rsp0_*, wr_rsp1_*  QPI write response channels
//   done                job complete, held until next start
//   overflow_err        sticky: an input line was dropped
module conv_output_writer #(
    parameter int ADDR_LMT        = 58,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int FIFO_DEPTH_LOG2 = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_LMT-1:0]    base_addr,
    input  logic [31:0]            num_cl,
    input  logic                   in_valid,
    input  logic [CACHE_WIDTH-1:0] in_data,
    output logic                   in_almostfull,
    output logic [ADDR_LMT-1:0]    wr_req_addr,
    output logic [MDATA-1:0]       wr_req_mdata,
    output logic [CACHE_WIDTH-1:0] wr_req_data,
    output logic                   wr_req_en,
    input  logic                   wr_req_almostfull,
    input  logic                   wr_rsp0_valid,
    input  logic [MDATA-1:0]       wr_rsp0_mdata,
    input  logic                   wr_rsp1_valid,
    input  logic [MDATA-1:0]       wr_rsp1_mdata,
    output logic                   done,
    output logic                   overflow_err
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] AF_LVL = CW'(DEPTH - 4);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e state_q, state_d;

    logic [CACHE_WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
    logic [CW-1:0]              count_q, count_d;

    logic [ADDR_LMT-1:0] base_q;
    logic [31:0]         num_q;
    logic [31:0]         accepted_q, issued_q, resp_q;

    logic                   afull_q;
    logic                   ovf_q;
    logic                   req_en_q;
    logic [ADDR_LMT-1:0]    req_addr_q;
    logic [MDATA-1:0]       req_mdata_q;
    logic [CACHE_WIDTH-1:0] req_data_q;

    logic idle_like;
    logic start_ok;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic resp_en;

    // Response tags are only of interest to simulation checkers.
    logic unused_mdata;
    assign unused_mdata = ^{wr_rsp0_mdata, wr_rsp1_mdata};

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign start_ok  = start && idle_like;
    // Full is taken from the registered count, so a simultaneous pop
    // does not make room for the push in the same cycle.
    assign full      = count_q[FIFO_DEPTH_LOG2];
    assign empty     = (count_q == '0);
    assign push      = in_valid && (state_q == RUN) &&
                       (accepted_q < num_q) && !full;
    assign pop       = (state_q == RUN) && !empty && !wr_req_almostfull;
    assign resp_en   = (state_q == RUN) || (state_q == DRAIN);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (num_cl == '0) ? DONE : RUN;
            end
            RUN: begin
                if (issued_q == num_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (resp_q == num_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            base_q      <= '0;
            num_q       <= '0;
            accepted_q  <= '0;
            issued_q    <= '0;
            resp_q      <= '0;
            afull_q     <= 1'b0;
            ovf_q       <= 1'b0;
            req_en_q    <= 1'b0;
            req_addr_q  <= '0;
            req_mdata_q <= '0;
            req_data_q  <= '0;
        end else begin
            count_q  <= count_d;
            afull_q  <= (count_d >= AF_LVL);
            req_en_q <= pop;
            if (in_valid && !push) ovf_q <= 1'b1;
            if (push) begin
                wptr_q     <= wptr_q + FIFO_DEPTH_LOG2'(1);
                accepted_q <= accepted_q + 32'd1;
            end
            if (pop) begin
                rptr_q      <= rptr_q + FIFO_DEPTH_LOG2'(1);
                req_data_q  <= mem_q[rptr_q];
                req_addr_q  <= base_q + ADDR_LMT'(issued_q);
                req_mdata_q <= issued_q[MDATA-1:0];
                issued_q    <= issued_q + 32'd1;
            end
            if (resp_en) begin
                resp_q <= resp_q + 32'(wr_rsp0_valid) + 32'(wr_rsp1_valid);
            end
            if (start_ok) begin
                base_q     <= base_addr;
                num_q      <= num_cl;
                accepted_q <= '0;
                issued_q   <= '0;
                resp_q     <= '0;
            end
        end
    end

    assign in_almostfull = afull_q;
    assign overflow_err  = ovf_q;
    assign wr_req_en     = req_en_q;
    assign wr_req_addr   = req_addr_q;
    assign wr_req_mdata  = req_mdata_q;
    assign wr_req_data   = req_data_q;

endmodule
